transpose_tile_pingpong: RTL and testbench

//  Streaming T x T tile transposer for the TRANSPOSE path: pixel-major activation beats (one pixel, T channels)
//  in, channel-major beats (one channel, T pixels) out, ready for packing into HBM weight layout.

---
 rtl/transpose_tile_pingpong.sv | 128 ++++++++++++
 tb/tb_transpose_tile_pingpong.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_tile_pingpong.sv
// transpose_tile_pingpong
// Streaming T x T tile transposer. Pixel-major beats (one row, T channels) are
// written into one of two tile banks; the other bank drains channel-major beats
// (one column, T rows). Partial tiles closed by in_last are zero padded on read.
module transpose_tile_pingpong #(
  parameter int T  = 8,
  parameter int DW = 16,
  parameter int RW = $clog2(T+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [T*DW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [T*DW-1:0] out_data,
  output logic            out_last,
  output logic [RW-1:0]   out_rows,
  output logic            busy
);

  localparam int PW = $clog2(T);
  localparam logic [PW-1:0] LAST_IDX = PW'(T-1);

  // Tile storage: bank_mem[bank][row] holds one full pixel row (T lanes).
  logic [T*DW-1:0]    bank_mem [2][T];

  logic [1:0]          full_reg, full_next;
  logic [1:0][RW-1:0]  rows_reg, rows_next;
  logic                wr_bank_reg, wr_bank_next;
  logic [PW-1:0]       wr_row_reg, wr_row_next;
  logic                rd_bank_reg, rd_bank_next;
  logic [PW-1:0]       rd_col_reg, rd_col_next;

  logic in_fire;
  logic out_fire;
  logic wr_close;
  logic rd_close;

  // Handshake qualifiers; flush cycles discard both sides.
  assign in_ready  = !full_reg[wr_bank_reg];
  assign out_valid = full_reg[rd_bank_reg];
  assign out_rows  = rows_reg[rd_bank_reg];
  assign out_last  = out_valid & (rd_col_reg == LAST_IDX);
  assign busy      = (|full_reg) | (wr_row_reg != '0);

  assign in_fire  = in_valid & in_ready & ~clr;
  assign out_fire = out_valid & out_ready & ~clr;
  assign wr_close = in_last | (wr_row_reg == LAST_IDX);
  assign rd_close = (rd_col_reg == LAST_IDX);

  // Row write into the filling bank; contents are never reset, validity comes from rows_reg.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank_mem[wr_bank_reg][wr_row_reg] <= in_data;
    end
  end

  // Column read: lane r picks element (r, rd_col); rows beyond the tile's count read as zero.
  for (genvar gi = 0; gi < T; gi++) begin : g_lane
    logic [T*DW-1:0] row_word;
    assign row_word = bank_mem[rd_bank_reg][gi];
    assign out_data[gi*DW +: DW] = (RW'(gi) < out_rows) ? row_word[rd_col_reg*DW +: DW] : '0;
  end

  // Next-state for bank flags, row counts and both pointers.
  always_comb begin
    full_next    = full_reg;
    rows_next    = rows_reg;
    wr_bank_next = wr_bank_reg;
    wr_row_next  = wr_row_reg;
    rd_bank_next = rd_bank_reg;
    rd_col_next  = rd_col_reg;
    if (clr) begin
      full_next    = '0;
      rows_next    = '0;
      wr_bank_next = 1'b0;
      wr_row_next  = '0;
      rd_bank_next = 1'b0;
      rd_col_next  = '0;
    end else begin
      // Fill side only ever targets an empty bank, drain side only a full one,
      // so the two updates below never touch the same bank in one cycle.
      if (in_fire) begin
        if (wr_close) begin
          full_next[wr_bank_reg] = 1'b1;
          rows_next[wr_bank_reg] = RW'(wr_row_reg) + RW'(1);
          wr_bank_next           = ~wr_bank_reg;
          wr_row_next            = '0;
        end else begin
          wr_row_next = wr_row_reg + PW'(1);
        end
      end
      if (out_fire) begin
        if (rd_close) begin
          full_next[rd_bank_reg] = 1'b0;
          rd_bank_next           = ~rd_bank_reg;
          rd_col_next            = '0;
        end else begin
          rd_col_next = rd_col_reg + PW'(1);
        end
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg    <= '0;
      rows_reg    <= '0;
      wr_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      rd_bank_reg <= 1'b0;
      rd_col_reg  <= '0;
    end else begin
      full_reg    <= full_next;
      rows_reg    <= rows_next;
      wr_bank_reg <= wr_bank_next;
      wr_row_reg  <= wr_row_next;
      rd_bank_reg <= rd_bank_next;
      rd_col_reg  <= rd_col_next;
    end
  end

endmodule

// File: tb/tb_transpose_tile_pingpong.sv
// Directed and randomised bench for transpose_tile_pingpong.
module tb_transpose_tile_pingpong;

  localparam int T  = 8;
  localparam int DW = 16;
  localparam int RW = $clog2(T+1);

  typedef struct packed {
    logic [T*DW-1:0] data;
    logic            last;
    logic [RW-1:0]   rows;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [T*DW-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [T*DW-1:0] out_data;
  logic            out_last;
  logic [RW-1:0]   out_rows;
  logic            busy;

  int    errors = 0;
  int    checks = 0;
  bit    in_acc;
  bit    out_acc;
  beat_t obs_q[$];
  beat_t exp_q[$];

  transpose_tile_pingpong #(.T(T), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_rows  (out_rows),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Input row r of a tile: lane c = base + r*16 + c.
  function automatic logic [T*DW-1:0] pix(input int base, input int r);
    logic [T*DW-1:0] v;
    v = '0;
    for (int c = 0; c < T; c++) v[c*DW +: DW] = DW'(base + r*16 + c);
    return v;
  endfunction

  // Expected output beat c of a tile built with pix(): lane r = element (r, c), zero past nrows.
  function automatic logic [T*DW-1:0] exp_beat(input int base, input int nrows, input int c);
    logic [T*DW-1:0] v;
    v = '0;
    for (int r = 0; r < T; r++) if (r < nrows) v[r*DW +: DW] = DW'(base + r*16 + c);
    return v;
  endfunction

  // One clock: called just after a falling edge with inputs driven; samples the
  // handshakes that the next rising edge will complete, then waits for the next falling edge.
  task automatic cyc();
    #2;
    in_acc  = rst_n && !clr && in_valid && in_ready;
    out_acc = rst_n && !clr && out_valid && out_ready;
    if (out_acc) obs_q.push_back(beat_t'{data: out_data, last: out_last, rows: out_rows});
    @(negedge clk);
  endtask

  task automatic send_tile(input int base, input int nrows, input bit close);
    int r = 0;
    int guard = 0;
    while (r < nrows && guard < 300) begin
      in_valid = 1'b1;
      in_data  = pix(base, r);
      in_last  = close && (r == nrows - 1);
      cyc();
      if (in_acc) r++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (r != nrows) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d rows, required %0d", r, nrows);
    end
  endtask

  task automatic wait_obs(input int n);
    int guard = 0;
    while (obs_q.size() < n && guard < 300) begin
      cyc();
      guard++;
    end
    checks++;
    if (obs_q.size() != n) begin
      errors++;
      $display("FAIL drain_count: got %0d beats, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_rows, busy} !== {1'b1, 1'b0, 1'b0, RW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b rows=%0d busy=%b, required 1 0 0 0 0",
               in_ready, out_valid, out_last, out_rows, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_full_tile();
    obs_q.delete();
    out_ready = 1'b1;
    send_tile(0, T, 1'b0);
    wait_obs(T);
    for (int c = 0; c < T && c < obs_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== beat_t'{data: exp_beat(0, T, c), last: (c == T-1), rows: RW'(T)}) begin
        errors++;
        $display("FAIL full_tile beat %0d: got data=%h last=%b rows=%0d, required data=%h last=%b rows=%0d",
                 c, obs_q[c].data, obs_q[c].last, obs_q[c].rows, exp_beat(0, T, c), (c == T-1), T);
      end
    end
  endtask

  task automatic test_partial();
    int bases[6] = '{'h100, 'h200, 'h300, 'h400, 'h500, 'h600};
    int nrows[6] = '{3, 8, 8, 3, 8, 1};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      obs_q.delete();
      send_tile(bases[k], nrows[k], nrows[k] < T);
      wait_obs(T);
      for (int c = 0; c < T && c < obs_q.size(); c++) begin
        checks++;
        if (obs_q[c] !== beat_t'{data: exp_beat(bases[k], nrows[k], c), last: (c == T-1), rows: RW'(nrows[k])}) begin
          errors++;
          $display("FAIL partial tile %0d beat %0d: got data=%h rows=%0d last=%b, required data=%h rows=%0d last=%b",
                   k, c, obs_q[c].data, obs_q[c].rows, obs_q[c].last,
                   exp_beat(bases[k], nrows[k], c), nrows[k], (c == T-1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int guard = 0;
    obs_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = (k < 24);
      in_data  = pix('h700 + 'h100 * (k / T), k % T);
      cyc();
      if (in_acc) k++;
    end
    checks++;
    if (k != 16 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got accepts=%0d rdy=%b vld=%b busy=%b, required 16 0 1 1", k, in_ready, out_valid, busy);
    end
    out_ready = 1'b1;
    while (k < 24 && guard < 100) begin
      in_valid = 1'b1;
      in_data  = pix('h700 + 'h100 * (k / T), k % T);
      cyc();
      if (in_acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != 24) begin
      errors++;
      $display("FAIL bp_resume: got accepts=%0d, required 24", k);
    end
    wait_obs(24);
    for (int j = 0; j < 24 && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j].data !== exp_beat('h700 + 'h100 * (j / T), T, j % T) || obs_q[j].last !== (j % T == T-1)) begin
        errors++;
        $display("FAIL bp_order beat %0d: got data=%h last=%b, required data=%h last=%b",
                 j, obs_q[j].data, obs_q[j].last, exp_beat('h700 + 'h100 * (j / T), T, j % T), (j % T == T-1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int low_cnt = 0;
    int first_out = -1;
    int last_out = -1;
    obs_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 150 && (k < 32 || obs_q.size() < 32); i++) begin
      in_valid = (k < 32);
      in_data  = pix('hA00 + 'h100 * (k / T), k % T);
      if (k < 32 && !in_ready) low_cnt++;
      cyc();
      if (in_acc) k++;
      if (out_acc) begin
        if (first_out < 0) first_out = i;
        last_out = i;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (low_cnt != 0 || k != 32) begin
      errors++;
      $display("FAIL stream_in: got ready_low=%0d accepts=%0d, required 0 32", low_cnt, k);
    end
    checks++;
    if (first_out != T) begin
      errors++;
      $display("FAIL stream_latency: got first out cycle %0d, required %0d", first_out, T);
    end
    checks++;
    if (obs_q.size() != 32 || last_out != T + 31) begin
      errors++;
      $display("FAIL stream_contig: got %0d beats ending cycle %0d, required 32 ending %0d", obs_q.size(), last_out, T + 31);
    end
    for (int j = 0; j < 32 && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j].data !== exp_beat('hA00 + 'h100 * (j / T), T, j % T)) begin
        errors++;
        $display("FAIL stream_data beat %0d: got %h, required %h", j, obs_q[j].data, exp_beat('hA00 + 'h100 * (j / T), T, j % T));
      end
    end
  endtask

  task automatic test_random();
    logic [T*DW-1:0] cur_rows [T];
    int    t = 0;
    int    r = 0;
    int    nrows_cur;
    int    guard = 0;
    bit    stalled;
    beat_t saved;
    beat_t b;
    beat_t ob;
    obs_q.delete();
    exp_q.delete();
    nrows_cur = 0;
    while ((t < 100 || exp_q.size() > 0) && guard < 30000) begin
      if (r == 0 && nrows_cur == 0) begin
        nrows_cur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, T-1) : T;
        for (int rr = 0; rr < T; rr++)
          for (int c = 0; c < T; c++) cur_rows[rr][c*DW +: DW] = DW'($urandom);
      end
      in_valid  = (t < 100) && ($urandom_range(0, 1) == 1);
      in_data   = cur_rows[r];
      in_last   = (r == nrows_cur - 1) && (nrows_cur < T || $urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      stalled   = out_valid && !out_ready;
      saved     = beat_t'{data: out_data, last: out_last, rows: out_rows};
      cyc();
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || beat_t'{data: out_data, last: out_last, rows: out_rows} !== saved) begin
          errors++;
          $display("FAIL rand_stable: got vld=%b data=%h, required vld=1 data=%h", out_valid, out_data, saved.data);
        end
      end
      if (in_acc) begin
        if (in_last || r == T - 1) begin
          for (int c = 0; c < T; c++) begin
            b.data = '0;
            for (int rr = 0; rr < T; rr++) if (rr <= r) b.data[rr*DW +: DW] = cur_rows[rr][c*DW +: DW];
            b.last = (c == T-1);
            b.rows = RW'(r + 1);
            exp_q.push_back(b);
          end
          t++;
          r = 0;
          nrows_cur = 0;
        end else begin
          r++;
        end
      end
      while (obs_q.size() > 0) begin
        ob = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got unexpected beat data=%h", ob.data);
        end else begin
          b = exp_q.pop_front();
          if (ob !== b) begin
            errors++;
            $display("FAIL rand_beat: got data=%h last=%b rows=%0d, required data=%h last=%b rows=%0d",
                     ob.data, ob.last, ob.rows, b.data, b.last, b.rows);
          end
        end
      end
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++;
    if (t != 100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete: got tiles=%0d pending=%0d, required 100 0", t, exp_q.size());
    end
  endtask

  task automatic test_midtile(input bit use_clr);
    obs_q.delete();
    out_ready = 1'b0;
    send_tile('hE00, T, 1'b0);
    send_tile('hF00, 5, 1'b0);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre clr=%0d: got busy=%b vld=%b, required 1 1", use_clr, busy, out_valid);
    end
    if (use_clr) begin
      clr = 1'b1; in_valid = 1'b1; in_data = pix('hF00, 5); out_ready = 1'b1;
      cyc();
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    end else begin
      rst_n = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({out_valid, in_ready, busy, out_rows} !== {1'b0, 1'b1, 1'b0, RW'(0)}) begin
      errors++;
      $display("FAIL mid_flush clr=%0d: got vld=%b rdy=%b busy=%b rows=%0d, required 0 1 0 0",
               use_clr, out_valid, in_ready, busy, out_rows);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs_q.delete();
    out_ready = 1'b1;
    send_tile('h120, T, 1'b0);
    wait_obs(T);
    for (int c = 0; c < T && c < obs_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== beat_t'{data: exp_beat('h120, T, c), last: (c == T-1), rows: RW'(T)}) begin
        errors++;
        $display("FAIL mid_recover clr=%0d beat %0d: got data=%h, required %h", use_clr, c, obs_q[c].data, exp_beat('h120, T, c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_midtile(1'b0);
    test_midtile(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
